// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: 2**ADDR_W-entry program memory, PC, one-deep read pipeline
// and a small prefetch FIFO feeding the decoder over valid/ready.
module instr_fetch_unit #(
    parameter int ADDR_W   = 4,
    parameter int INS_W    = 8,
    parameter int DEPTH    = 2,
    parameter int RESET_PC = 0,
    parameter logic [INS_W-1:0] HALT_OP = 8'hFF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [INS_W-1:0]  prog_data,
    input  logic              run,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [INS_W-1:0]  ins_out,
    output logic [ADDR_W-1:0] ins_pc,
    output logic [ADDR_W-1:0] fetch_pc,
    output logic              halted
);

    localparam int MEM_D = 1 << ADDR_W;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic [INS_W-1:0]  ins;
        logic [ADDR_W-1:0] pc;
    } fetch_rsp_t;

    logic [INS_W-1:0]  mem [MEM_D];
    logic [INS_W-1:0]  rd_data;
    logic [ADDR_W-1:0] rd_addr;
    logic              inflight;
    fetch_rsp_t        fifo_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W:0]    occ;
    logic              pop, push, halt_hit, issue;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Occupancy counts the in-flight read so a returning word always has a slot.
    always_comb begin
        pop      = ins_valid & ins_ready;
        push     = inflight & ~redirect_valid;
        halt_hit = push & (rd_data == HALT_OP);
        occ      = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);
        issue    = run & ~halted & ~halt_hit & ~redirect_valid & (occ < (CNT_W+1)'(DEPTH));
    end

    // Storage without reset: memory, read register and FIFO payload.
    always_ff @(posedge clk) begin
        if (prog_we)
            mem[prog_addr] <= prog_data;
        if (issue) begin
            rd_data <= mem[fetch_pc];
            rd_addr <= fetch_pc;
        end
        if (push && !rst)
            fifo_q[wr_ptr] <= '{ins: rd_data, pc: rd_addr};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= ADDR_W'(RESET_PC);
            inflight <= 1'b0;
            halted   <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else if (redirect_valid) begin
            fetch_pc <= redirect_pc;
            inflight <= 1'b0;
            halted   <= 1'b0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
        end else begin
            inflight <= issue;
            if (issue)
                fetch_pc <= fetch_pc + 1'b1;
            if (halt_hit)
                halted <= 1'b1;
            if (push)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop)
                rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

    always_comb begin
        ins_valid = (count != '0);
        ins_out   = ins_valid ? fifo_q[rd_ptr].ins : '0;
        ins_pc    = ins_valid ? fifo_q[rd_ptr].pc  : '0;
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed stimulus queues expected deliveries,
// a per-DUT monitor pops them on each decoder handshake.
module tb_instr_fetch_unit;

    typedef struct {
        logic [7:0] ins;
        logic [3:0] pc;
    } exp_t;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    // DUT A: default parameters
    logic       rst = 1'b1, prog_we = 1'b0, run = 1'b0, redirect_valid = 1'b0, ins_ready = 1'b0;
    logic [3:0] prog_addr = '0, redirect_pc = '0;
    logic [7:0] prog_data = '0;
    logic       ins_valid, halted;
    logic [7:0] ins_out;
    logic [3:0] ins_pc, fetch_pc;

    // DUT B: RESET_PC = 14 for the wrap case
    logic       b_rst = 1'b1, b_prog_we = 1'b0, b_run = 1'b0, b_ready = 1'b0;
    logic [3:0] b_prog_addr = '0;
    logic [7:0] b_prog_data = '0;
    logic       b_valid, b_halted;
    logic [7:0] b_ins_out;
    logic [3:0] b_ins_pc, b_fetch_pc;

    instr_fetch_unit u_dut (
        .clk(clk), .rst(rst), .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
        .run(run), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .ins_valid(ins_valid), .ins_ready(ins_ready), .ins_out(ins_out), .ins_pc(ins_pc),
        .fetch_pc(fetch_pc), .halted(halted)
    );

    instr_fetch_unit #(.RESET_PC(14)) u_wrap (
        .clk(clk), .rst(b_rst), .prog_we(b_prog_we), .prog_addr(b_prog_addr), .prog_data(b_prog_data),
        .run(b_run), .redirect_valid(1'b0), .redirect_pc(4'h0),
        .ins_valid(b_valid), .ins_ready(b_ready), .ins_out(b_ins_out), .ins_pc(b_ins_pc),
        .fetch_pc(b_fetch_pc), .halted(b_halted)
    );

    exp_t qa[$], qb[$];
    int   n_chk = 0, n_fail = 0;

    always @(negedge clk) begin
        if (!rst && ins_valid && ins_ready) begin
            n_chk++;
            if (qa.size() == 0) begin
                n_fail++;
                $display("FAIL a_unexpected: got ins=%h pc=%h, want nothing", ins_out, ins_pc);
            end else begin
                exp_t e;
                e = qa.pop_front();
                if (ins_out !== e.ins || ins_pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL a_deliver: got ins=%h pc=%h, want ins=%h pc=%h", ins_out, ins_pc, e.ins, e.pc);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!b_rst && b_valid && b_ready) begin
            n_chk++;
            if (qb.size() == 0) begin
                n_fail++;
                $display("FAIL b_unexpected: got ins=%h pc=%h, want nothing", b_ins_out, b_ins_pc);
            end else begin
                exp_t e;
                e = qb.pop_front();
                if (b_ins_out !== e.ins || b_ins_pc !== e.pc) begin
                    n_fail++;
                    $display("FAIL b_deliver: got ins=%h pc=%h, want ins=%h pc=%h", b_ins_out, b_ins_pc, e.ins, e.pc);
                end
            end
        end
    end

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic load_a(input logic [3:0] a, input logic [7:0] d);
        prog_we = 1'b1; prog_addr = a; prog_data = d;
        step();
        prog_we = 1'b0;
    endtask

    task automatic load_b(input logic [3:0] a, input logic [7:0] d);
        b_prog_we = 1'b1; b_prog_addr = a; b_prog_data = d;
        step();
        b_prog_we = 1'b0;
    endtask

    task automatic push_prog;
        qa.push_back('{8'h11, 4'h0});
        qa.push_back('{8'h22, 4'h1});
        qa.push_back('{8'h33, 4'h2});
        qa.push_back('{8'hFF, 4'h3});
    endtask

    initial begin
        // reset state
        step(2);
        chk("rst_valid", ins_valid, 0);
        chk("rst_ins_out", ins_out, 0);
        chk("rst_ins_pc", ins_pc, 0);
        chk("rst_fetch_pc", fetch_pc, 0);
        chk("rst_halted", halted, 0);
        rst = 1'b0;
        load_a(4'h0, 8'h11); load_a(4'h1, 8'h22); load_a(4'h2, 8'h33);
        load_a(4'h3, 8'hFF); load_a(4'h4, 8'h44); load_a(4'hA, 8'h5C);
        load_a(4'hB, 8'h66);

        // basic streaming to HALT
        push_prog();
        ins_ready = 1'b1; run = 1'b1;
        step();
        chk("lat_edge1_valid", ins_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", ins_valid, 1);
        end
        chk("stream_halted", halted, 1);
        chk("stream_fetch_pc", fetch_pc, 4);
        step(3);
        chk("post_halt_valid", ins_valid, 0);
        chk("post_halt_fetch_pc", fetch_pc, 4);

        // backpressure
        rst = 1'b1; ins_ready = 1'b0;
        step();
        rst = 1'b0;
        push_prog();
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("bp_hold_ins", ins_out, 8'h11);
        end
        chk("bp_ins_pc", ins_pc, 0);
        chk("bp_fetch_pc", fetch_pc, 2);
        ins_ready = 1'b1;
        step(6);
        chk("bp_drain_valid", ins_valid, 0);
        chk("bp_halted", halted, 1);
        chk("bp_queue_empty", qa.size(), 0);

        // redirect with full occupancy and a read in flight
        rst = 1'b1; ins_ready = 1'b0;
        step();
        rst = 1'b0;
        qa.push_back('{8'h11, 4'h0});
        step(3);
        ins_ready = 1'b1;
        step();
        ins_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 4'hA;
        qa.push_back('{8'h5C, 4'hA});
        step();
        redirect_valid = 1'b0;
        chk("redir_valid_next", ins_valid, 0);
        step();
        run = 1'b0;
        chk("redir_valid_2", ins_valid, 0);
        step();
        chk("redir_valid_3", ins_valid, 1);
        chk("redir_ins", ins_out, 8'h5C);
        chk("redir_pc", ins_pc, 4'hA);
        ins_ready = 1'b1;
        step(2);
        chk("redir_no_stale", ins_valid, 0);
        chk("redir_fetch_pc", fetch_pc, 4'hB);

        // redirect after halt
        rst = 1'b1;
        step();
        rst = 1'b0; run = 1'b1;
        push_prog();
        step(6);
        chk("rh_halted_set", halted, 1);
        redirect_valid = 1'b1; redirect_pc = 4'h0;
        push_prog();
        step();
        redirect_valid = 1'b0;
        chk("rh_halted_clr", halted, 0);
        chk("rh_fetch_pc", fetch_pc, 0);
        step();
        chk("rh_restart_pc", fetch_pc, 1);
        step(5);
        chk("rh_halted_again", halted, 1);
        chk("rh_queue_empty", qa.size(), 0);

        // reset mid-run with two entries buffered
        rst = 1'b1; ins_ready = 1'b0;
        step();
        rst = 1'b0;
        step(3);
        chk("mr_buffered", ins_valid, 1);
        rst = 1'b1;
        step();
        chk("mr_valid", ins_valid, 0);
        chk("mr_ins_out", ins_out, 0);
        chk("mr_fetch_pc", fetch_pc, 0);
        chk("mr_halted", halted, 0);
        rst = 1'b0; ins_ready = 1'b1;
        push_prog();
        step(7);
        chk("mr_mem_kept_halt", halted, 1);
        chk("mr_queue_empty", qa.size(), 0);

        // PC wrap on the RESET_PC=14 instance
        step();
        b_rst = 1'b0;
        chk("wrap_rst_pc", b_fetch_pc, 4'hE);
        load_b(4'hE, 8'h01); load_b(4'hF, 8'h02); load_b(4'h0, 8'h03); load_b(4'h1, 8'hFF);
        qb.push_back('{8'h01, 4'hE});
        qb.push_back('{8'h02, 4'hF});
        qb.push_back('{8'h03, 4'h0});
        qb.push_back('{8'hFF, 4'h1});
        b_run = 1'b1; b_ready = 1'b1;
        step(7);
        chk("wrap_halted", b_halted, 1);
        chk("wrap_fetch_pc", b_fetch_pc, 4'h2);
        chk("wrap_queue_empty", qb.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Upstream instruction supply stage for the 4-bit CPU core. It holds a 16-entry x 8-bit program memory that is loaded through a write port. A program counter fetches instructions into a small prefetch FIFO, which presents them to the decoder over a valid/ready handshake. It supports PC redirect (jump/branch) with flush, and halts fetching on the HALT opcode.

Parameters:
ADDR_W, 4, program address / PC width (memory depth = 2**ADDR_W)
INS_W, 8, instruction width
DEPTH, 2, prefetch FIFO entries (>=1)
RESET_PC, 0, PC value loaded on reset
HALT_OP, 8'hFF, opcode that stops fetching

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous active-high reset
prog_we  in  1  program memory write enable
prog_addr  in  ADDR_W  program memory write address
prog_data  in  INS_W  program memory write data
run  in  1  fetch enable; 0 = no new fetches issued
redirect_valid  in  1  load new PC and flush
redirect_pc  in  ADDR_W  redirect target
ins_valid  out  1  FIFO head valid
ins_ready  in  1  decoder accepts head this cycle
ins_out  out  INS_W  FIFO head instruction (0 when empty)
ins_pc  out  ADDR_W  address of ins_out (0 when empty)
fetch_pc  out  ADDR_W  next address to be fetched
halted  out  1  HALT_OP has been fetched; fetching stopped

Behaviour:
- Reset (rst=1 at edge): fetch_pc=RESET_PC, FIFO empty, in-flight flag 0, halted=0. Outputs ins_valid=0, ins_out=0, ins_pc=0. Memory contents are not reset. Reset overrides every other input, including mid-fetch.
- Memory: synchronous read, 1-cycle latency. Write on prog_we at the edge. A same-address read and write in one cycle returns the OLD data.
- Issue condition at an edge: run & ~halted & ~redirect_valid & (count + inflight - pop < DEPTH).
  - On issue: read mem[fetch_pc], set inflight=1, record the address, fetch_pc <= fetch_pc+1. fetch_pc wraps from 2**ADDR_W-1 to 0.
  - No issue: inflight=0.
- Return: on the edge after an issue, push {data, addr} into the FIFO. If data==HALT_OP, set halted=1 on that edge. The HALT instruction itself is delivered to the decoder.
- Pop: ins_valid & ins_ready at an edge removes the head. Push and pop in the same cycle are both performed, and count stays unchanged. The FIFO never overflows, because the credit check counts the in-flight read.
- Latency: with FIFO empty and run rising, the first edge with run=1 issues, and ins_valid is high after the second edge. With ins_ready held at 1 and DEPTH>=2, throughput is one instruction per cycle.
- Redirect (priority over issue, push, pop, halt):
  - On the edge with redirect_valid=1: the FIFO is emptied, the in-flight read is discarded (no push), fetch_pc <= redirect_pc, halted <= 0.
  - ins_valid is 0 on the next cycle.
  - A handshake occurring in the redirect cycle counts as consumed by the decoder.
  - Fetch resumes on the following edge if run=1.
- run deasserted: no new issue. An in-flight read still completes and is pushed. The FIFO drains normally.
- ins_out and ins_pc are stable while ins_valid=1 and ins_ready=0.
- halted stays set until rst or redirect. prog_we does not clear it.

Test Plan:
- Load mem[0..3]=8'h11,8'h22,8'h33,8'hFF, rst, then run=1 with ins_ready=1. Required: ins_valid rises after the 2nd edge; the decoder receives 11/22/33/FF with ins_pc 0/1/2/3 on consecutive cycles; halted=1; nothing is delivered after FF; fetch_pc=4.
- Backpressure: same program with ins_ready=0 for 5 cycles. Required: FIFO holds 2 entries (11 @0, 22 @1); fetch_pc=2; ins_out stays 8'h11. Releasing ready gives 11, 22, 33, FF in order with no loss or duplication.
- Redirect while FIFO full and a read in flight, redirect_pc=4'hA, mem[A]=8'h5C. Required: ins_valid=0 on the next cycle, then 8'h5C with ins_pc=A two edges later, and no stale entries.
- Wrap: RESET_PC=4'hE, mem[E]=8'h01, mem[F]=8'h02, mem[0]=8'h03. Required: delivered pcs E, F, 0 and data 01, 02, 03.
- Redirect after halt: halted=1, then redirect to 0. Required: halted=0 on the next cycle and fetching restarts at 0.
- Reset mid-run with 2 entries buffered. Required: ins_valid=0, ins_out=0, fetch_pc=RESET_PC on the next cycle; memory contents are preserved.
